// File: rtl/instr_line_buf.sv
// Instruction line buffer: FIFO of I-cache lines, issues one instruction per cycle from the head line.
// Optional zero-latency bypass from an empty buffer: define INSTR_LINE_BUF_BYPASS_EN.
module instr_line_buf #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned ILEN       = 32,
   parameter int unsigned LINE_INSTR = 16,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned OFFSET     = 2,
   localparam int unsigned IDX_W     = $clog2(LINE_INSTR),
   localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       flush_i,
   input  logic                       line_valid_i,
   output logic                       line_ready_o,
   input  logic [XLEN-1:0]            line_pc_i,
   input  logic [LINE_INSTR*ILEN-1:0] line_data_i,
   output logic                       instr_valid_o,
   input  logic                       instr_ready_i,
   output logic [ILEN-1:0]            instr_o,
   output logic [XLEN-1:0]            instr_pc_o,
   output logic [CNT_W-1:0]           occupancy_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PC_W  = XLEN - OFFSET;

   typedef logic [LINE_INSTR-1:0][ILEN-1:0] line_t;

   line_t            line_mem [DEPTH];
   logic [PC_W-1:0]  pc_mem   [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] in_off;
   logic             push, buf_issue, pop, last;
   logic             byp_take, byp_drop;
   logic             unused_pc_lo;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Byte-offset bits of the PC never select anything.
   assign unused_pc_lo = ^line_pc_i[OFFSET-1:0];

   assign in_off       = line_pc_i[IDX_W+OFFSET-1:OFFSET];
   assign line_ready_o = (count_q != CNT_W'(DEPTH));
   assign occupancy_o  = count_q;
   assign head_nxt     = next_ptr(head_q);
   assign last         = (idx_q == IDX_W'(LINE_INSTR - 1));
   assign buf_issue    = (count_q != '0) && !flush_i && instr_ready_i;
   assign pop          = buf_issue && last;

`ifdef INSTR_LINE_BUF_BYPASS_EN
   line_t byp_line;
   logic  byp_sel;
   assign byp_line = line_data_i;
   assign byp_sel  = (count_q == '0) && line_valid_i && !flush_i;
   assign byp_take = byp_sel && instr_ready_i;
   // A line fully consumed through the bypass never needs a slot.
   assign byp_drop = byp_take && (in_off == IDX_W'(LINE_INSTR - 1));
`else
   assign byp_take = 1'b0;
   assign byp_drop = 1'b0;
`endif

   assign push = line_valid_i && line_ready_o && !byp_drop;

   // Issue selection from the head entry (or the incoming line when bypassing).
   always_comb begin
      instr_valid_o = 1'b0;
      instr_o       = '0;
      instr_pc_o    = '0;
`ifdef INSTR_LINE_BUF_BYPASS_EN
      if (byp_sel) begin
         instr_valid_o = 1'b1;
         instr_o       = byp_line[in_off];
         instr_pc_o    = {line_pc_i[XLEN-1:OFFSET], OFFSET'(0)};
      end
`endif
      if ((count_q != '0) && !flush_i) begin
         instr_valid_o = 1'b1;
         instr_o       = line_mem[head_q][idx_q];
         instr_pc_o    = {pc_mem[head_q][PC_W-1:IDX_W], idx_q, OFFSET'(0)};
      end
   end

   // Pointer, count and word-index next state.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      idx_d   = idx_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         idx_d   = '0;
      end else begin
         if (push) tail_d = next_ptr(tail_q);
         if (pop)  head_d = head_nxt;
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         if (buf_issue && !last) begin
            idx_d = idx_q + IDX_W'(1);
         end else if (pop) begin
            if (count_q > CNT_W'(1)) idx_d = pc_mem[head_nxt][IDX_W-1:0];
            else if (push)           idx_d = in_off;
            else                     idx_d = '0;
         end else if (push && (count_q == '0)) begin
            idx_d = byp_take ? in_off + IDX_W'(1) : in_off;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            line_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         if (push && !flush_i) begin
            line_mem[tail_q] <= line_data_i;
            pc_mem[tail_q]   <= line_pc_i[XLEN-1:OFFSET];
         end
      end
   end

endmodule
